// File: rtl/ldtu_link_sequencer.sv
// Link start-up/recovery FSM for the LiTE-DTU datapath: calibration wait, flush, synch alignment, run.
// Define LDTU_SEQ_SYNCH_TIMEOUT_EN to compile in the SYNCH timeout, retry counting and link_error.
module ldtu_link_sequencer #(
  parameter int unsigned FLUSH_CYCLES  = 8,
  parameter int unsigned HS_CONFIRM    = 4,
  parameter int unsigned SYNCH_TIMEOUT = 1023,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned LOSS_LIMIT    = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CALIBRATION_BUSY,
  input  logic       TEST_ENABLE,
  input  logic       handshake,
  input  logic       losing_data,
  input  logic       resynch_req,
  output logic       flush_b,
  output logic       synch,
  output logic       datapath_en,
  output logic [2:0] seq_state,
  output logic [1:0] retry_cnt,
  output logic       link_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALIB = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_SYNCH = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_TEST  = 3'd5;

  localparam logic [9:0] FLUSH_LAST  = 10'(FLUSH_CYCLES - 1);
  localparam logic [2:0] HS_TARGET   = 3'(HS_CONFIRM);
  localparam logic [4:0] LOSS_TARGET = 5'(LOSS_LIMIT);

  logic [2:0] state_q, state_d;
  logic [9:0] flush_cnt_q, flush_cnt_d;
  logic [2:0] hs_run_q, hs_run_d, hs_inc;
  logic [4:0] loss_q, loss_d, loss_inc;
  logic       hs_confirm, loss_hit, timeout;
  logic       flush_b_q, flush_b_d, synch_q, synch_d, den_q, den_d;

  // Confirm and loss limits act on the count including the current cycle.
  assign hs_inc     = (hs_run_q == 3'd7) ? 3'd7 : hs_run_q + 3'd1;
  assign loss_inc   = (loss_q == 5'd31) ? 5'd31 : loss_q + 5'd1;
  assign hs_confirm = handshake && (hs_inc == HS_TARGET);
  assign loss_hit   = losing_data && (loss_inc == LOSS_TARGET);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      hs_run_q    <= '0;
      loss_q      <= '0;
      flush_b_q   <= 1'b0;
      synch_q     <= 1'b0;
      den_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      hs_run_q    <= hs_run_d;
      loss_q      <= loss_d;
      flush_b_q   <= flush_b_d;
      synch_q     <= synch_d;
      den_q       <= den_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (TEST_ENABLE) begin
      state_d = S_TEST;
    end else if (CALIBRATION_BUSY && (state_q != S_TEST)) begin
      state_d = S_CALIB;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_CALIB;
        S_CALIB: state_d = S_FLUSH;
        S_FLUSH: if (flush_cnt_q == FLUSH_LAST) state_d = S_SYNCH;
        S_SYNCH: begin
          if (hs_confirm)   state_d = S_RUN;
          else if (timeout) state_d = S_FLUSH;
        end
        S_RUN:   if (loss_hit || resynch_req) state_d = S_FLUSH;
        S_TEST:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Counters restart from zero on every state entry and hold at their terminal value.
  always_comb begin
    flush_cnt_d = '0;
    hs_run_d    = '0;
    loss_d      = '0;
    if ((state_q == S_FLUSH) && (state_d == S_FLUSH))
      flush_cnt_d = (flush_cnt_q == FLUSH_LAST) ? flush_cnt_q : flush_cnt_q + 10'd1;
    if ((state_q == S_SYNCH) && (state_d == S_SYNCH) && handshake)
      hs_run_d = hs_inc;
    if ((state_q == S_RUN) && (state_d == S_RUN) && losing_data)
      loss_d = loss_inc;
  end

  always_comb begin
    flush_b_d = !((state_d == S_IDLE) || (state_d == S_CALIB) ||
                  (state_d == S_FLUSH) || (state_d == S_TEST));
    synch_d   = (state_d == S_SYNCH);
    den_d     = (state_d == S_RUN);
  end

`ifdef LDTU_SEQ_SYNCH_TIMEOUT_EN
  localparam logic [9:0] TIMEOUT_LAST = 10'(SYNCH_TIMEOUT);
  localparam logic [1:0] RETRY_LIMIT  = 2'(MAX_RETRY);

  logic [9:0] timer_q, timer_d;
  logic [1:0] retry_q, retry_d, retry_inc;
  logic       link_q, link_d;

  assign timeout   = (state_q == S_SYNCH) && (timer_q == TIMEOUT_LAST);
  assign retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

  always_comb begin
    timer_d = '0;
    retry_d = retry_q;
    link_d  = link_q;
    if ((state_q == S_SYNCH) && (state_d == S_SYNCH))
      timer_d = (timer_q == TIMEOUT_LAST) ? timer_q : timer_q + 10'd1;
    if ((state_q == S_SYNCH) && (state_d == S_RUN)) begin
      retry_d = '0;
    end else if ((state_q == S_SYNCH) && (state_d == S_FLUSH)) begin
      retry_d = retry_inc;
      if (retry_inc == RETRY_LIMIT) link_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_q <= '0;
      retry_q <= '0;
      link_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      retry_q <= retry_d;
      link_q  <= link_d;
    end
  end

  assign retry_cnt  = retry_q;
  assign link_error = link_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{10'(SYNCH_TIMEOUT), 2'(MAX_RETRY)};
  assign timeout    = 1'b0;
  assign retry_cnt  = 2'd0;
  assign link_error = 1'b0;
`endif

  assign flush_b     = flush_b_q;
  assign synch       = synch_q;
  assign datapath_en = den_q;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_ldtu_link_sequencer.sv
// Scoreboard bench for ldtu_link_sequencer: per-cycle expected output words are queued as
// stimulus is driven and compared one time unit after each rising edge.
module tb_ldtu_link_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CALIBRATION_BUSY = 1'b0;
  logic       TEST_ENABLE = 1'b0;
  logic       handshake = 1'b0;
  logic       losing_data = 1'b0;
  logic       resynch_req = 1'b0;
  logic       flush_b, synch, datapath_en, link_error;
  logic [2:0] seq_state;
  logic [1:0] retry_cnt;

  logic [8:0] exp_q[$];
  logic [8:0] got, exp;
  int vectors = 0;
  int errors  = 0;

  always #5 CLK = ~CLK;

  ldtu_link_sequencer dut (
    .CLK(CLK), .RST(RST), .CALIBRATION_BUSY(CALIBRATION_BUSY), .TEST_ENABLE(TEST_ENABLE),
    .handshake(handshake), .losing_data(losing_data), .resynch_req(resynch_req),
    .flush_b(flush_b), .synch(synch), .datapath_en(datapath_en), .seq_state(seq_state),
    .retry_cnt(retry_cnt), .link_error(link_error)
  );

  // Expected word {flush_b, synch, datapath_en, seq_state, retry_cnt, link_error}.
  function automatic logic [8:0] exp_word(input int st, input int rt, input int le);
    logic fb;
    fb = !((st == 0) || (st == 1) || (st == 2) || (st == 5));
    return {fb, (st == 3), (st == 4), 3'(st), 2'(rt), le[0]};
  endfunction

  function automatic logic [8:0] obs();
    return {flush_b, synch, datapath_en, seq_state, retry_cnt, link_error};
  endfunction

  // State after edge e of a clean start with calibration idle and handshake high.
  function automatic int startup_st(input int e);
    return (e == 1) ? 1 : (e <= 9) ? 2 : (e <= 13) ? 3 : 4;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset(input logic hs, input logic busy);
    RST = 1'b1;
    TEST_ENABLE = 1'b0;
    losing_data = 1'b0;
    resynch_req = 1'b0;
    handshake = hs;
    CALIBRATION_BUSY = busy;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    exp_q.push_back(exp_word(0, 0, 0));
    got = obs(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin errors++; $display("FAIL reset_before_edge got=%b exp=%b", got, exp); end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(exp_word(0, 0, 0));
      step();
      got = obs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin errors++; $display("FAIL reset_held i=%0d got=%b exp=%b", i, got, exp); end
    end
  endtask

  task automatic test_startup();
    apply_reset(1'b1, 1'b0);
    for (int e = 1; e <= 16; e++) begin
      exp_q.push_back(exp_word(startup_st(e), 0, 0));
      step();
      got = obs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin errors++; $display("FAIL startup e=%0d got=%b exp=%b", e, got, exp); end
    end
  endtask

  task automatic test_calib_hold();
    apply_reset(1'b1, 1'b1);
    for (int e = 1; e <= 63; e++) begin
      if (e <= 50) handshake = 1'($urandom_range(0, 1));
      else begin handshake = 1'b1; CALIBRATION_BUSY = 1'b0; end
      exp_q.push_back(exp_word((e <= 50) ? 1 : (e <= 58) ? 2 : (e <= 62) ? 3 : 4, 0, 0));
      step();
      got = obs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin errors++; $display("FAIL calib_hold e=%0d got=%b exp=%b", e, got, exp); end
    end
  endtask

  task automatic test_hs_pattern();
    int pat[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    apply_reset(1'b0, 1'b0);
    for (int e = 1; e <= 18; e++) begin
      if (e >= 11) handshake = 1'(pat[e - 11]);
      exp_q.push_back(exp_word((e == 1) ? 1 : (e <= 9) ? 2 : (e <= 17) ? 3 : 4, 0, 0));
      step();
      got = obs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin errors++; $display("FAIL hs_pattern e=%0d got=%b exp=%b", e, got, exp); end
    end
  endtask

  // Runs from RUN: 15 lossy cycles, one clean, then 16 lossy with a coincident resynch_req.
  task automatic test_loss();
    for (int i = 0; i < 32; i++) begin
      losing_data = (i != 15);
      resynch_req = (i == 31);
      exp_q.push_back(exp_word((i == 31) ? 2 : 4, 0, 0));
      step();
      got = obs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin errors++; $display("FAIL loss_burst i=%0d got=%b exp=%b", i, got, exp); end
    end
    losing_data = 1'b0;
    resynch_req = 1'b0;
    handshake = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      if (j >= 9) handshake = 1'b1;
      exp_q.push_back(exp_word((j <= 7) ? 2 : (j <= 11) ? 3 : 4, 0, 0));
      step();
      got = obs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin errors++; $display("FAIL loss_reflush j=%0d got=%b exp=%b", j, got, exp); end
    end
  endtask

  // Runs from RUN with handshake high.
  task automatic test_resynch();
    for (int j = 0; j <= 12; j++) begin
      resynch_req = (j == 0);
      exp_q.push_back(exp_word((j <= 7) ? 2 : (j <= 11) ? 3 : 4, 0, 0));
      step();
      got = obs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin errors++; $display("FAIL resynch j=%0d got=%b exp=%b", j, got, exp); end
    end
    for (int k = 0; k < 5; k++) begin
      resynch_req = (k == 0);
      TEST_ENABLE = (k <= 1);
      CALIBRATION_BUSY = (k >= 1) && (k <= 3);
      exp_q.push_back(exp_word((k <= 1) ? 5 : (k == 2) ? 0 : (k == 3) ? 1 : 2, 0, 0));
      step();
      got = obs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin errors++; $display("FAIL resynch_test k=%0d got=%b exp=%b", k, got, exp); end
    end
    CALIBRATION_BUSY = 1'b0;
  endtask

`ifdef LDTU_SEQ_SYNCH_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset(1'b0, 1'b0);
    for (int e = 1; e <= 9; e++) begin
      exp_q.push_back(exp_word((e == 1) ? 1 : 2, 0, 0));
      step();
      got = obs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin errors++; $display("FAIL timeout_start e=%0d got=%b exp=%b", e, got, exp); end
    end
    for (int a = 0; a <= 4; a++) begin
      int r_s, r_f;
      r_s = (a > 3) ? 3 : a;
      r_f = (a + 1 > 3) ? 3 : a + 1;
      for (int c = 0; c <= ((a == 4) ? 1024 : 1023); c++) begin
        handshake = (a == 4) && (c >= 1021);
        if (c == 1024) exp_q.push_back(exp_word(4, 0, 1));
        else           exp_q.push_back(exp_word(3, r_s, (r_s >= 3) ? 1 : 0));
        step();
        got = obs(); exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin errors++; $display("FAIL timeout_synch a=%0d c=%0d got=%b exp=%b", a, c, got, exp); end
      end
      if (a < 4) begin
        for (int f = 0; f < 8; f++) begin
          exp_q.push_back(exp_word(2, r_f, (r_f >= 3) ? 1 : 0));
          step();
          got = obs(); exp = exp_q.pop_front(); vectors++;
          if (got !== exp) begin errors++; $display("FAIL timeout_flush a=%0d f=%0d got=%b exp=%b", a, f, got, exp); end
        end
      end
    end
  endtask
`else
  task automatic test_no_timeout();
    apply_reset(1'b0, 1'b0);
    for (int e = 1; e <= 1204; e++) begin
      losing_data = (e < 1200) ? 1'($urandom_range(0, 1)) : 1'b0;
      resynch_req = (e < 1200) ? ($urandom_range(0, 15) == 0) : 1'b0;
      handshake = (e >= 1201);
      exp_q.push_back(exp_word((e == 1) ? 1 : (e <= 9) ? 2 : (e <= 1203) ? 3 : 4, 0, 0));
      step();
      got = obs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin errors++; $display("FAIL no_timeout e=%0d got=%b exp=%b", e, got, exp); end
    end
  endtask
`endif

  task automatic test_async_reset();
    apply_reset(1'b0, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      exp_q.push_back(exp_word((e == 1) ? 1 : (e <= 9) ? 2 : 3, 0, 0));
      step();
      got = obs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin errors++; $display("FAIL async_pre e=%0d got=%b exp=%b", e, got, exp); end
    end
    #2;
    RST = 1'b1;
    exp_q.push_back(exp_word(0, 0, 0));
    #1;
    got = obs(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin errors++; $display("FAIL async_reset got=%b exp=%b", got, exp); end
    apply_reset(1'b1, 1'b0);
    for (int e = 1; e <= 14; e++) begin
      exp_q.push_back(exp_word(startup_st(e), 0, 0));
      step();
      got = obs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin errors++; $display("FAIL async_restart e=%0d got=%b exp=%b", e, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_calib_hold();
    test_hs_pattern();
    test_loss();
    test_resynch();
`ifdef LDTU_SEQ_SYNCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
